ctech_lib_clk_gate_seq: RTL and testbench



---
 rtl/ctech_lib_clk_gate_seq_pkg.sv | 29 ++
 rtl/ctech_lib_clk_gate_seq_if.sv | 13 +
 rtl/ctech_lib_clk_gate.sv | 16 +
 rtl/ctech_lib_clk_gate_seq_rr.sv | 30 +++
 rtl/ctech_lib_clk_gate_seq.sv | 115 +++++++++++
 tb/tb_ctech_lib_clk_gate_seq.sv | 281 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ctech_lib_clk_gate_seq_pkg.sv
// Shared types, width helpers and parameter legality checks for the
// ctech_lib_clk_gate_seq clock-gating sequencer.
package ctech_lib_clk_gate_seq_pkg;

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef enum logic [0:0] {
    SCAN = ST_SCAN,
    HOLD = ST_HOLD
  } state_e;

  // Stagger and dwell counters share one width sized for the larger limit.
  function automatic int unsigned cnt_w(input int unsigned stagger, input int unsigned dwell);
    int unsigned m;
    m = (stagger > dwell) ? stagger : dwell;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned stagger,
                                   input int unsigned dwell);
    return (n >= 1) && (n <= 32) && (stagger >= 1) && (dwell >= 1);
  endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_seq_if.sv
// Request/applied-enable bundle between power-management control (master)
// and the clock-gating sequencer (slave).
interface ctech_lib_clk_gate_seq_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] req_en;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] gclk;
  logic              busy;

  modport master (output req_en, input clk_en, input gclk, input busy);
  modport slave  (input req_en, output clk_en, output gclk, output busy);
endinterface

// File: rtl/ctech_lib_clk_gate.sv
// Latch-based clock-gate cell: enable (or test-enable) captured while clk is
// low, so gclk never glitches when the enable changes during the high phase.
module ctech_lib_clk_gate (
  input  logic i_clk,
  input  logic i_en,
  input  logic i_te,
  output logic o_gclk
);
  logic r_en_lat;

  always_latch begin
    if (!i_clk) r_en_lat = i_en | i_te;
  end

  assign o_gclk = i_clk & r_en_lat;
endmodule

// File: rtl/ctech_lib_clk_gate_seq_rr.sv
// Round-robin picker: first set bit of i_elig searching upward from i_ptr,
// wrapping at NUM_CH-1 -> 0.
module ctech_lib_clk_gate_seq_rr
  import ctech_lib_clk_gate_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned PW = ptr_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_elig,
  input  logic [PW-1:0]     i_ptr,
  output logic [PW-1:0]     o_grant,
  output logic              o_valid
);
  logic [PW:0] w_idx;

  // i_ptr < NUM_CH and offset < NUM_CH, so one conditional subtract wraps.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(NUM_CH)) w_idx = w_idx - (PW+1)'(NUM_CH);
      if (!o_valid && i_elig[w_idx[PW-1:0]]) begin
        o_valid = 1'b1;
        o_grant = w_idx[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/ctech_lib_clk_gate_seq.sv
// Multi-channel clock-gating sequencer: one enable change per stagger window,
// minimum per-channel dwell. Macro CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN adds
// the fscan_clkungate port driving every gate cell's test-enable.
module ctech_lib_clk_gate_seq
  import ctech_lib_clk_gate_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned STAGGER_CYC = 2,
  parameter int unsigned MIN_DWELL   = 4
) (
  input  logic clk,
  input  logic rst_b,
`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
  input  logic fscan_clkungate,
`endif
  ctech_lib_clk_gate_seq_if.slave bus
);
  localparam int unsigned CW = cnt_w(STAGGER_CYC, MIN_DWELL);
  localparam int unsigned PW = ptr_w(NUM_CH);
  localparam logic [CW-1:0] DW_SAT   = CW'(MIN_DWELL - 1);
  localparam logic [CW-1:0] STG_LOAD = CW'(STAGGER_CYC - 1);

  if (!params_ok(NUM_CH, STAGGER_CYC, MIN_DWELL)) begin : g_bad_params
    $error("ctech_lib_clk_gate_seq: illegal NUM_CH/STAGGER_CYC/MIN_DWELL");
  end

  state_e            r_state;
  logic [CW-1:0]     r_stg;
  logic [PW-1:0]     r_rr;
  logic [NUM_CH-1:0] r_clk_en;
  logic [CW-1:0]     r_dwell [NUM_CH];

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_elig;
  logic [PW-1:0]     w_grant;
  logic              w_gvalid;
  logic [PW-1:0]     w_rr_next;
  logic [NUM_CH-1:0] w_gclk;
  logic              w_te;

  assign w_pending = bus.req_en ^ r_clk_en;

  // A dwell counter parked at DW_SAT means the next toggle lands at least
  // MIN_DWELL edges after the previous one.
  always_comb begin
    w_elig = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_elig[k] = w_pending[k] && (r_dwell[k] == DW_SAT);
    end
  end

  ctech_lib_clk_gate_seq_rr #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .i_elig  (w_elig),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_valid (w_gvalid)
  );

  assign w_rr_next = (w_grant == PW'(NUM_CH - 1)) ? '0 : w_grant + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state  <= SCAN;
      r_stg    <= '0;
      r_rr     <= '0;
      r_clk_en <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) r_dwell[k] <= DW_SAT;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (r_dwell[k] != DW_SAT) r_dwell[k] <= r_dwell[k] + CW'(1);
      end
      case (r_state)
        SCAN: begin
          if (w_gvalid) begin
            r_clk_en[w_grant] <= ~r_clk_en[w_grant];
            r_dwell[w_grant]  <= '0;
            r_rr              <= w_rr_next;
            if (STAGGER_CYC > 1) begin
              r_stg   <= STG_LOAD;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          r_stg <= r_stg - CW'(1);
          if (r_stg == CW'(1)) r_state <= SCAN;
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  // Masked during reset so busy reads 0 while the enables are being forced off.
  assign bus.busy   = rst_b & ((r_state == HOLD) | (|w_pending));
  assign bus.clk_en = r_clk_en;

`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
  assign w_te = fscan_clkungate;
`else
  assign w_te = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cg
    ctech_lib_clk_gate u_cg (
      .i_clk  (clk),
      .i_en   (r_clk_en[k]),
      .i_te   (w_te),
      .o_gclk (w_gclk[k])
    );
  end

  assign bus.gclk = w_gclk;
endmodule

// File: tb/tb_ctech_lib_clk_gate_seq.sv
// Directed bench for ctech_lib_clk_gate_seq with NUM_CH=4, STAGGER_CYC=2,
// MIN_DWELL=4; expected values are hand-derived per edge.
module tb_ctech_lib_clk_gate_seq;
  logic clk = 1'b0;
  logic rst_b;
`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
  logic fscan_clkungate = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;

  ctech_lib_clk_gate_seq_if #(.NUM_CH(4)) bus ();

  ctech_lib_clk_gate_seq #(
    .NUM_CH      (4),
    .STAGGER_CYC (2),
    .MIN_DWELL   (4)
  ) dut (
    .clk             (clk),
    .rst_b           (rst_b),
`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
    .fscan_clkungate (fscan_clkungate),
`endif
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // Sample 1 time unit after the rising edge, while clk is high.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.req_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== 4'h0) begin
        n_err++; $display("FAIL rst_clk_en edge %0d: got %h exp 0", i, bus.clk_en);
      end
      n_vec++;
      if (bus.busy !== 1'b0) begin
        n_err++; $display("FAIL rst_busy edge %0d: got %b exp 0", i, bus.busy);
      end
      if (i > 0) begin
        n_vec++;
        if (bus.gclk !== 4'h0) begin
          n_err++; $display("FAIL rst_gclk edge %0d: got %h exp 0", i, bus.gclk);
        end
      end
    end
  endtask

  task automatic test_powerup();
    logic [3:0] exp_en [8];
    logic       exp_busy [8];
    logic [3:0] exp_g;
    exp_en   = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_b = 1'b1;
    bus.req_en = 4'h0;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL pu_idle_busy: got %b exp 0", bus.busy);
    end
    bus.req_en = 4'hF;
    #1;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL pu_busy_pre: got %b exp 1", bus.busy);
    end
    exp_g = 4'h0;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== exp_en[j]) begin
        n_err++; $display("FAIL pu_clk_en step %0d: got %h exp %h", j, bus.clk_en, exp_en[j]);
      end
      n_vec++;
      if (bus.busy !== exp_busy[j]) begin
        n_err++; $display("FAIL pu_busy step %0d: got %b exp %b", j, bus.busy, exp_busy[j]);
      end
      n_vec++;
      if (bus.gclk !== exp_g) begin
        n_err++; $display("FAIL pu_gclk step %0d: got %h exp %h", j, bus.gclk, exp_g);
      end
      exp_g = exp_en[j];
    end
  endtask

  task automatic test_dwell();
    logic [3:0] exp;
    bus.req_en = 4'hE;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'hE) begin
      n_err++; $display("FAIL dw_clear: got %h exp e", bus.clk_en);
    end
    repeat (6) tick();
    bus.req_en = 4'hF;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'hF) begin
      n_err++; $display("FAIL dw_set: got %h exp f", bus.clk_en);
    end
    bus.req_en = 4'hE;
    for (int j = 1; j <= 4; j++) begin
      tick();
      exp = (j < 4) ? 4'hF : 4'hE;
      n_vec++;
      if (bus.clk_en !== exp) begin
        n_err++; $display("FAIL dw_hold +%0d: got %h exp %h", j, bus.clk_en, exp);
      end
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL dw_busy_end: got %b exp 0", bus.busy);
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] exp_a [3];
    logic [3:0] exp_b [6];
    exp_a = '{4'h4, 4'h4, 4'h5};
    exp_b = '{4'h7, 4'h7, 4'h3, 4'h3, 4'h2, 4'h2};
    // Clear ch1 alone so the pointer lands on 2.
    bus.req_en = 4'hC;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'hC) begin
      n_err++; $display("FAIL rr_setup: got %h exp c", bus.clk_en);
    end
    repeat (6) tick();
    bus.req_en = 4'h5;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== exp_a[j]) begin
        n_err++; $display("FAIL rr_wrap step %0d: got %h exp %h", j, bus.clk_en, exp_a[j]);
      end
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rr_wrap_busy: got %b exp 0", bus.busy);
    end
    repeat (5) tick();
    // ch0, ch1, ch2 pending together: order from pointer 1 is 1, 2, 0.
    bus.req_en = 4'h2;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== exp_b[j]) begin
        n_err++; $display("FAIL rr_order step %0d: got %h exp %h", j, bus.clk_en, exp_b[j]);
      end
    end
  endtask

  task automatic test_cancel();
    bus.req_en = 4'h0;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'h0) begin
      n_err++; $display("FAIL cx_setup: got %h exp 0", bus.clk_en);
    end
    repeat (6) tick();
    bus.req_en = 4'h4;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'h4) begin
      n_err++; $display("FAIL cx_ch2_set: got %h exp 4", bus.clk_en);
    end
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL cx_hold_busy: got %b exp 1", bus.busy);
    end
    bus.req_en = 4'h6;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'h4) begin
      n_err++; $display("FAIL cx_no_toggle_hold: got %h exp 4", bus.clk_en);
    end
    bus.req_en = 4'h4;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL cx_busy_cancel: got %b exp 0", bus.busy);
    end
    for (int j = 0; j < 2; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== 4'h4) begin
        n_err++; $display("FAIL cx_no_toggle_after %0d: got %h exp 4", j, bus.clk_en);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_a [3];
    logic [3:0] exp_b [3];
    exp_a = '{4'h5, 4'h5, 4'h7};
    exp_b = '{4'h1, 4'h1, 4'h3};
    bus.req_en = 4'h7;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== exp_a[j]) begin
        n_err++; $display("FAIL mr_setup step %0d: got %h exp %h", j, bus.clk_en, exp_a[j]);
      end
    end
    rst_b = 1'b0;
    tick();
    n_vec++;
    if (bus.clk_en !== 4'h0) begin
      n_err++; $display("FAIL mr_clk_en: got %h exp 0", bus.clk_en);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL mr_busy: got %b exp 0", bus.busy);
    end
    rst_b = 1'b1;
    bus.req_en = 4'hF;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++;
      if (bus.clk_en !== exp_b[j]) begin
        n_err++; $display("FAIL mr_restart step %0d: got %h exp %h", j, bus.clk_en, exp_b[j]);
      end
    end
  endtask

`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
  task automatic test_scan_ungate();
    rst_b = 1'b0;
    bus.req_en = 4'h0;
    tick();
    rst_b = 1'b1;
    fscan_clkungate = 1'b1;
    tick();
    n_vec++;
    if (bus.gclk !== 4'hF) begin
      n_err++; $display("FAIL su_gclk_on: got %h exp f", bus.gclk);
    end
    n_vec++;
    if (bus.clk_en !== 4'h0) begin
      n_err++; $display("FAIL su_clk_en: got %h exp 0", bus.clk_en);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL su_busy: got %b exp 0", bus.busy);
    end
    fscan_clkungate = 1'b0;
    tick();
    n_vec++;
    if (bus.gclk !== 4'h0) begin
      n_err++; $display("FAIL su_gclk_off: got %h exp 0", bus.gclk);
    end
  endtask
`endif

  initial begin
    rst_b = 1'b0;
    bus.req_en = 4'hF;
    test_reset();
    test_powerup();
    test_dwell();
    test_rr_wrap();
    test_cancel();
    test_mid_reset();
`ifdef CTECH_LIB_CLK_GATE_SEQ_SCAN_UNGATE_EN
    test_scan_ungate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
